// File: rtl/mult_rr_sched_pkg.sv
// Shared types for the RNS multiplier scheduler: slot vectors, widened products,
// requester tag and the per-slot product helper.
package mult_rr_sched_pkg;

    localparam int N_SLOTS        = 4;
    localparam int RNS_PRIME_BITS = 16;
    localparam int MULT_WIDE_BITS = 2 * RNS_PRIME_BITS + 1;
    localparam int NUM_REQ_DEF    = 4;
    localparam int REQ_ID_W       = $clog2(NUM_REQ_DEF);

    typedef logic [N_SLOTS-1:0][RNS_PRIME_BITS-1:0] vec_t;
    typedef logic [N_SLOTS-1:0][MULT_WIDE_BITS-1:0] wide_vec_t;
    typedef logic [REQ_ID_W-1:0]                    req_id_t;

    // Full-width unsigned product with one spare MSB so the modular reducer
    // downstream can use a single representation for sums and products.
    function automatic logic [MULT_WIDE_BITS-1:0] slot_mul(
        input logic [RNS_PRIME_BITS-1:0] a,
        input logic [RNS_PRIME_BITS-1:0] b
    );
        logic [2*RNS_PRIME_BITS-1:0] p;
        p = a * b;
        return {1'b0, p};
    endfunction

endpackage

// File: rtl/mult.sv
// Slot-wise RNS vector multiplier: purely combinational, no modular reduction.
module mult
    import mult_rr_sched_pkg::*;
(
    input  vec_t      a,
    input  vec_t      b,
    output wide_vec_t prod
);

    always_comb begin
        prod = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            prod[s] = slot_mul(a[s], b[s]);
        end
    end

endmodule

// File: rtl/mult_rr_sched_rr_arbiter.sv
// N-way round-robin arbiter: search starts at the pointer, pointer moves past
// the winner only when the grant is actually taken (en high).
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid
);

    localparam logic [ID_W:0]   N_EXT = (ID_W + 1)'(N);
    localparam logic [ID_W-1:0] LAST  = ID_W'(N - 1);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W-1:0] off;
    logic [N-1:0]    rot;
    logic [ID_W:0]   sum;

    // Rotate so the pointer position lands on bit 0; the lowest set bit of the
    // rotated vector is then the winner's distance from the pointer.
    always_comb begin
        rot       = N'({req, req} >> ptr);
        gnt_valid = |req;
        off       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = ID_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_EXT) sum = sum - N_EXT;
        gnt_id = sum[ID_W-1:0];
        gnt    = '0;
        if (en && gnt_valid) gnt[gnt_id] = 1'b1;
        ptr_next = (gnt_id == LAST) ? '0 : gnt_id + ID_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en && gnt_valid) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/mult_rr_sched.sv
// Shares one slot-wise multiplier among NUM_REQ requesters; products return tagged
// with the requester id. Define MULT_RR_SCHED_PERF_EN for grant/stall counters.
module mult_rr_sched
    import mult_rr_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int PIPE_STAGES = 2,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  vec_t [NUM_REQ-1:0]      req_a,
    input  vec_t [NUM_REQ-1:0]      req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output wide_vec_t               resp_prod,
    output logic                    busy
`ifdef MULT_RR_SCHED_PERF_EN
    ,
    output logic [NUM_REQ-1:0][31:0] perf_grants,
    output logic [31:0]              perf_stall
`endif
);

    logic [PIPE_STAGES:1] stg_valid;
    logic [PIPE_STAGES:1] stg_en;
    logic [ID_W-1:0]      stg_id   [1:PIPE_STAGES];
    wide_vec_t            stg_prod [1:PIPE_STAGES];

    logic            stall;
    logic            can_accept;
    logic            chain;
    logic            accept;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    vec_t            a_sel;
    vec_t            b_sel;
    wide_vec_t       mult_prod;

    assign stall      = stg_valid[PIPE_STAGES] & ~resp_ready;
    assign can_accept = ~stall | ~stg_valid[1];
    assign accept     = gnt_valid & can_accept;

    // A stage may load whenever it is empty or its successor is loading, so
    // bubbles are squeezed out even while the output is back-pressured.
    always_comb begin
        chain                = ~stg_valid[PIPE_STAGES] | resp_ready;
        stg_en               = '0;
        stg_en[PIPE_STAGES]  = chain;
        for (int k = PIPE_STAGES - 1; k >= 1; k--) begin
            chain     = ~stg_valid[k] | chain;
            stg_en[k] = chain;
        end
    end

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .en        (can_accept),
        .gnt       (req_ready),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    assign a_sel = req_a[gnt_id];
    assign b_sel = req_b[gnt_id];

    mult u_mult (
        .a    (a_sel),
        .b    (b_sel),
        .prod (mult_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            for (int k = 1; k <= PIPE_STAGES; k++) begin
                stg_id[k]   <= '0;
                stg_prod[k] <= '0;
            end
        end else begin
            if (stg_en[1]) begin
                stg_valid[1] <= accept;
                if (accept) begin
                    stg_id[1]   <= gnt_id;
                    stg_prod[1] <= mult_prod;
                end
            end
            for (int k = 2; k <= PIPE_STAGES; k++) begin
                if (stg_en[k]) begin
                    stg_valid[k] <= stg_valid[k-1];
                    if (stg_valid[k-1]) begin
                        stg_id[k]   <= stg_id[k-1];
                        stg_prod[k] <= stg_prod[k-1];
                    end
                end
            end
        end
    end

    assign resp_valid = stg_valid[PIPE_STAGES];
    assign resp_id    = stg_id[PIPE_STAGES];
    assign resp_prod  = stg_prod[PIPE_STAGES];
    assign busy       = |stg_valid;

`ifdef MULT_RR_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grants <= '0;
            perf_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && perf_grants[i] != '1) begin
                    perf_grants[i] <= perf_grants[i] + 32'd1;
                end
            end
            if (stall && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
